ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- It is the counterpart of the keyboard receive path that already consumes ps2_clk/ps2_data.
- Runs in the clk65MHz domain and drives the PS/2 lines open-drain through pad-level tristates in top.
- Implements inhibit, request-to-send, 11-bit frame, device ACK check and timeout.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_sync_edge.sv | 42 ++++
 rtl/ps2_host_tx.sv | 176 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state names, command bytes, frame size
// and the odd-parity helper used when building a host-to-device frame.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int PS2_FRAME_BITS = 11;

  // Parity bit that makes data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and completion status between a client and
// the PS/2 host transmitter.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronizes one raw PS/2 line into the clk domain and flags its
// falling edges with a registered one-cycle tick. Needs SYNC_STAGES >= 2.
// Flops reset to 1 because idle PS/2 lines float high, so leaving reset
// never produces a spurious edge.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_sync,
  output logic fall_tick
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   prev_r;
  logic                   fall_r;

  assign d_sync    = chain_r[SYNC_STAGES-1];
  assign fall_tick = fall_r;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= {SYNC_STAGES{1'b1}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d_in};
    end
  end

  // Remember the previous synchronized level and register the 1->0 tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      prev_r <= d_sync;
      fall_r <= prev_r & ~d_sync;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// shifts out start/data/parity/stop on device clock falls, checks the
// device ACK and bounds the whole exchange with a timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 7800,
  parameter int TIMEOUT_CYCLES = 1300000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_INHIBIT   = INHIBIT;
  localparam logic [2:0] ST_RTS       = RTS;
  localparam logic [2:0] ST_BITS      = BITS;
  localparam logic [2:0] ST_ACK       = ACK;
  localparam logic [2:0] ST_WAIT_IDLE = WAIT_IDLE;

  logic [2:0]       state_r;
  logic [9:0]       shift_r;
  logic [3:0]       bit_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             clk_oe_r;
  logic             data_oe_r;
  logic             done_r;
  logic             ack_err_r;
  logic             timeout_r;

  logic clk_sync_s;
  logic clk_fall_s;
  logic data_sync_s;
  // The transmitter never needs the data line's edges.
  logic data_fall_unused_s;
  logic handshake_s;
  logic to_expired_s;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk       (clk),
    .rst       (rst),
    .d_in      (ps2_clk_in),
    .d_sync    (clk_sync_s),
    .fall_tick (clk_fall_s)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk       (clk),
    .rst       (rst),
    .d_in      (ps2_data_in),
    .d_sync    (data_sync_s),
    .fall_tick (data_fall_unused_s)
  );

  assign bus.tx_ready   = (state_r == ST_IDLE);
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.tx_done    = done_r;
  assign bus.tx_ack_err = ack_err_r;
  assign bus.tx_timeout = timeout_r;
  assign ps2_clk_oe     = clk_oe_r;
  assign ps2_data_oe    = data_oe_r;

  assign handshake_s  = bus.tx_valid & (state_r == ST_IDLE);
  assign to_expired_s = (to_cnt_r == TO_LAST);

  // Frame sequencer: line drive, counters, shift register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= 10'd0;
      bit_cnt_r <= 4'd0;
      inh_cnt_r <= {INH_W{1'b0}};
      to_cnt_r  <= {TO_W{1'b0}};
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (handshake_s) begin
            shift_r   <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
            bit_cnt_r <= 4'd0;
            inh_cnt_r <= {INH_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            clk_oe_r  <= 1'b1;
            state_r   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          // Glitches on the clock line are ignored while we hold it low.
          if (inh_cnt_r == INH_LAST) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b1;
            state_r   <= ST_RTS;
          end else begin
            inh_cnt_r <= inh_cnt_r + INH_W'(1'b1);
          end
        end
        ST_RTS, ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
          if (to_expired_s) begin
            // Timeout wins over any clock fall seen in the same cycle.
            timeout_r <= 1'b1;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
            case (state_r)
              ST_RTS: begin
                clk_oe_r  <= 1'b0;
                data_oe_r <= 1'b1;
                state_r   <= ST_BITS;
              end
              ST_BITS: begin
                if (clk_fall_s) begin
                  data_oe_r <= ~shift_r[0];
                  shift_r   <= {1'b0, shift_r[9:1]};
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                  if (bit_cnt_r == LAST_BIT) begin
                    state_r <= ST_ACK;
                  end
                end
              end
              ST_ACK: begin
                data_oe_r <= 1'b0;
                if (clk_fall_s) begin
                  if (!data_sync_s) begin
                    state_r <= ST_WAIT_IDLE;
                  end else begin
                    ack_err_r <= 1'b1;
                    state_r   <= ST_IDLE;
                  end
                end
              end
              ST_WAIT_IDLE: begin
                if (clk_sync_s && data_sync_s) begin
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
                end
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, and every captured frame and status pulse is compared with the
// frame the protocol rules predict for the byte that was sent.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  wire  ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  wire  ps2_data_in = ~(ps2_data_oe | dev_data_low);

  int n_tests = 0;
  int n_fail  = 0;
  int mon_oe, mon_done, mon_err, mon_to;

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(3000), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Count inhibit cycles and status pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ps2_clk_oe)     mon_oe++;
      if (bus.tx_done)    mon_done++;
      if (bus.tx_ack_err) mon_err++;
      if (bus.tx_timeout) mon_to++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Frame as seen on the wire: start 0, D0..D7, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic clr_mon();
    @(posedge clk);
    #1;
    mon_oe = 0; mon_done = 0; mon_err = 0; mon_to = 0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  // Device model: waits for request-to-send, then generates n falls.
  task automatic device_frame(input bit give_ack, input int n_pulses, output logic [10:0] seen);
    int guard;
    seen  = 11'd0;
    guard = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("rts_seen", 32'(guard < 500), 32'd1);
    if (guard < 500) begin
      repeat ($urandom_range(5, 30)) @(negedge clk);
      seen[0] = ps2_data_in;
      for (int i = 1; i <= n_pulses; i++) begin
        if (i == 11 && give_ack) dev_data_low = 1'b1;
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        if (i <= 10) seen[i] = ps2_data_in;
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (bus.tx_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_ready_bound"}, 32'(g < 200), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit give_ack, input string tag);
    logic [10:0] seen;
    clr_mon();
    start_tx(b);
    device_frame(give_ack, 11, seen);
    wait_ready(tag);
    repeat (4) @(negedge clk);
    check({tag, "_bits"}, 32'(seen), 32'(frame_of(b)));
    check({tag, "_inhibit_len"}, 32'(mon_oe), 32'd10);
    check({tag, "_done"}, 32'(mon_done), give_ack ? 32'd1 : 32'd0);
    check({tag, "_ack_err"}, 32'(mon_err), give_ack ? 32'd0 : 32'd1);
    check({tag, "_timeout"}, 32'(mon_to), 32'd0);
    check({tag, "_oe_idle"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check({tag, "_ready"}, {30'd0, bus.tx_ready, bus.busy}, 32'd2);
  endtask

  initial begin
    logic [10:0] s1, s2, dummy;
    logic [7:0]  b, b2;
    int          n;
    bit          seen_done;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_pulses", {29'd0, bus.tx_done, bus.tx_ack_err, bus.tx_timeout}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(CMD_SET_LEDS, 1'b1, "ed");
    run_frame(8'h00, 1'b1, "par00");
    run_frame(8'hFF, 1'b1, "parff");
    run_frame(8'h01, 1'b1, "par01");
    for (int k = 0; k < 5; k++) run_frame(8'($urandom), 1'b1, "rand");
    run_frame(8'($urandom), 1'b0, "noack");

    // Device never clocks: timeout 3000 cycles after clock release.
    clr_mon();
    start_tx(8'($urandom));
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (bus.tx_timeout !== 1'b1 && n < 4000);
    check("to_latency", 32'(n), 32'd3000);
    check("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("to_ready", 32'(bus.tx_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("to_pulses", 32'(mon_to * 100 + mon_err * 10 + mon_done), 32'd100);
    run_frame(CMD_ENABLE, 1'b1, "after_to");

    // Reset while bit D4 (forced 0, so data is pulled low) is on the wire.
    clr_mon();
    b = 8'($urandom) & 8'hEF;
    start_tx(b);
    device_frame(1'b1, 5, dummy);
    check("rst_mid_data_low", 32'(ps2_data_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_mid_pulses", 32'(mon_to + mon_err + mon_done), 32'd0);
    run_frame(CMD_RESET, 1'b1, "after_rst");

    // tx_valid held with changing data; second byte back-to-back.
    clr_mon();
    b  = 8'($urandom);
    b2 = 8'($urandom);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    fork
      begin
        device_frame(1'b1, 11, s1);
        device_frame(1'b1, 11, s2);
      end
      begin
        n = 0;
        seen_done = 1'b0;
        @(negedge clk);
        while (!seen_done && n < 3000) begin
          if (bus.tx_done === 1'b1) begin
            seen_done = 1'b1;
          end else begin
            bus.tx_data = 8'($urandom);
            @(negedge clk);
            n++;
          end
        end
        check("b2b_done_seen", 32'(seen_done), 32'd1);
        bus.tx_data = b2;
        @(negedge clk);
        check("b2b_inhibit_next", 32'(ps2_clk_oe), 32'd1);
        bus.tx_valid = 1'b0;
      end
    join
    wait_ready("b2b");
    repeat (4) @(negedge clk);
    check("b2b_first_bits", 32'(s1), 32'(frame_of(b)));
    check("b2b_second_bits", 32'(s2), 32'(frame_of(b2)));
    check("b2b_done_count", 32'(mon_done), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
